// File: rtl/custom_instruction_initiator.sv
// APB3 bridge that issues one custom-instruction command and captures the result.
// Ports: clk/reset, APB3 slave (PADDR..PSLVERR), cmd/rsp stream master, irq.
// Optional: define CI_TIMEOUT_EN for the TIMEOUT register and abort counter.
module custom_instruction_initiator #(
    parameter int ADDR_W      = 8,
    parameter int LAT_W       = 16,
    parameter int TIMEOUT_RST = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [9:0]        cmd_function_id,
    output logic [31:0]       cmd_inputs_0,
    output logic [31:0]       cmd_inputs_1,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [31:0]       rsp_outputs_0,
    output logic              irq
);

    localparam logic [5:0] IDX_CTRL   = 6'h00;
    localparam logic [5:0] IDX_STATUS = 6'h01;
    localparam logic [5:0] IDX_FUNC   = 6'h02;
    localparam logic [5:0] IDX_IN0    = 6'h03;
    localparam logic [5:0] IDX_IN1    = 6'h04;
    localparam logic [5:0] IDX_OUT    = 6'h05;
    localparam logic [5:0] IDX_TMO    = 6'h06;
    localparam logic [5:0] IDX_LAT    = 6'h07;
    localparam logic [5:0] IDX_IRQEN  = 6'h08;

    localparam logic [31:0] LP_TMO_RST = 32'(TIMEOUT_RST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RSP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [9:0]       r_func;
    logic [31:0]      r_in0;
    logic [31:0]      r_in1;
    logic [31:0]      r_out;
    logic [LAT_W-1:0] r_lat;
    logic             r_irq_en;
    logic             r_done;
    logic             r_tmo;

    logic [5:0]  w_idx;
    logic        w_busy;
    logic        w_wr;
    logic        w_err_sel;
    logic        w_slverr;
    logic        w_wr_ok;
    logic        w_start;
    logic        w_clear;
    logic        w_cmd_fire;
    logic        w_rsp_fire;
    logic        w_expire;
    logic [31:0] w_tmo_rd;
    logic        w_unused;

    assign w_idx      = PADDR[7:2];
    assign w_busy     = (r_state != S_IDLE);
    assign w_wr       = PSEL & PENABLE & PWRITE;
    assign w_cmd_fire = (r_state == S_CMD) & cmd_ready;
    assign w_rsp_fire = (r_state == S_RSP) & rsp_valid;

    // Writes that would disturb an in-flight command are flagged while busy.
    always_comb begin
        w_err_sel = 1'b0;
        case (w_idx)
            IDX_CTRL: w_err_sel = PWDATA[0];
            IDX_FUNC, IDX_IN0, IDX_IN1: w_err_sel = 1'b1;
`ifdef CI_TIMEOUT_EN
            IDX_TMO: w_err_sel = 1'b1;
`endif
            default: w_err_sel = 1'b0;
        endcase
    end

    assign w_slverr = w_wr & w_busy & w_err_sel;
    assign w_wr_ok  = w_wr & ~w_slverr;
    // A start can only survive the error filter while idle.
    assign w_start  = w_wr_ok & (w_idx == IDX_CTRL) & PWDATA[0];
    assign w_clear  = w_wr_ok & (w_idx == IDX_CTRL) & PWDATA[1];

`ifdef CI_TIMEOUT_EN
    logic [31:0] r_timeout;
    logic [31:0] r_tmo_cnt;

    // Loaded value 0 never reaches 1, so TIMEOUT=0 disables the abort.
    assign w_expire = w_busy & (r_tmo_cnt == 32'd1);
    assign w_tmo_rd = r_timeout;
    assign w_unused = ^PADDR[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout <= LP_TMO_RST;
            r_tmo_cnt <= '0;
        end else begin
            if (w_wr_ok && w_idx == IDX_TMO) begin
                r_timeout <= PWDATA;
            end
            if (w_start) begin
                r_tmo_cnt <= r_timeout;
            end else if (w_busy && r_tmo_cnt != '0) begin
                r_tmo_cnt <= r_tmo_cnt - 32'd1;
            end
        end
    end
`else
    assign w_expire = 1'b0;
    assign w_tmo_rd = '0;
    assign w_unused = ^{PADDR[1:0], LP_TMO_RST};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A response in the expiry cycle still completes normally.
    always_comb begin
        w_state_nxt = r_state;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                cmd_valid = 1'b1;
                if (w_expire) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cmd_fire) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                rsp_ready = 1'b1;
                if (w_rsp_fire || w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_func   <= '0;
            r_in0    <= '0;
            r_in1    <= '0;
            r_out    <= '0;
            r_lat    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                case (w_idx)
                    IDX_FUNC:  r_func   <= PWDATA[9:0];
                    IDX_IN0:   r_in0    <= PWDATA;
                    IDX_IN1:   r_in1    <= PWDATA;
                    IDX_IRQEN: r_irq_en <= PWDATA[0];
                    default:   ;
                endcase
            end
            // Clear first, then start; start also clears the flags.
            if (w_clear || w_start) begin
                r_done <= 1'b0;
                r_tmo  <= 1'b0;
            end
            if (w_rsp_fire) begin
                r_out  <= rsp_outputs_0;
                r_done <= 1'b1;
            end else if (w_expire) begin
                r_tmo  <= 1'b1;
            end
            // LATENCY counts busy cycles, frozen in the final one.
            if (w_start) begin
                r_lat <= LAT_W'(1);
            end else if (w_busy && !w_rsp_fire && !w_expire
                         && r_lat != '1) begin
                r_lat <= r_lat + LAT_W'(1);
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        case (w_idx)
            IDX_STATUS: PRDATA = {29'd0, r_tmo, r_done, w_busy};
            IDX_FUNC:   PRDATA = {22'd0, r_func};
            IDX_IN0:    PRDATA = r_in0;
            IDX_IN1:    PRDATA = r_in1;
            IDX_OUT:    PRDATA = r_out;
            IDX_TMO:    PRDATA = w_tmo_rd;
            IDX_LAT:    PRDATA = 32'(r_lat);
            IDX_IRQEN:  PRDATA = {31'd0, r_irq_en};
            default:    PRDATA = '0;
        endcase
    end

    assign PREADY          = 1'b1;
    assign PSLVERR         = w_slverr;
    assign cmd_function_id = r_func;
    assign cmd_inputs_0    = r_in0;
    assign cmd_inputs_1    = r_in1;
    assign irq             = r_irq_en & (r_done | r_tmo);

endmodule
